// File: rtl/pipe_stage_chain.sv
// Parametrised valid/allow_in pipeline skeleton with per-stage stall, younger-stage flush
// and optional per-stage stall counters (enabled by PIPE_STALL_CNT_EN).
module pipe_stage_chain #(
  parameter int unsigned NUM_STAGES = 5,
  parameter int unsigned BUS_W      = 64
) (
  input  logic                          clk,
  input  logic                          resetn,
  input  logic                          in_valid,
  output logic                          in_allow_in,
  input  logic [BUS_W-1:0]              in_bus,
  input  logic [NUM_STAGES-1:0]         stage_ready_go,
  input  logic [NUM_STAGES*BUS_W-1:0]   stage_next_bus,
  input  logic [NUM_STAGES-1:0]         flush,
  output logic [NUM_STAGES-1:0]         stage_valid,
  output logic [NUM_STAGES*BUS_W-1:0]   stage_bus,
  output logic                          out_valid,
  input  logic                          out_allow_in,
  output logic [BUS_W-1:0]              out_bus
`ifdef PIPE_STALL_CNT_EN
  ,
  output logic [NUM_STAGES*32-1:0]      perf_stall_cnt
`endif
);

  localparam int unsigned CNT_W = 32;

  logic [NUM_STAGES:0]   allow;
  logic [NUM_STAGES-1:0] kill_in;
  logic [NUM_STAGES-1:0] kill_hold;
  logic [NUM_STAGES-1:0] src_valid;
  logic [NUM_STAGES-1:0] load;
  logic [BUS_W-1:0]      src_bus [NUM_STAGES];

  // Back-pressure chain runs oldest to youngest; flush OR-reduction accumulates the same way.
  always_comb begin : chain_comb
    logic a;
    logic f;
    a         = out_allow_in;
    f         = 1'b0;
    allow     = '0;
    kill_in   = '0;
    kill_hold = '0;
    src_valid = '0;
    load      = '0;
    for (int k = 0; k < int'(NUM_STAGES); k++) src_bus[k] = '0;

    allow[NUM_STAGES] = out_allow_in;
    for (int k = int'(NUM_STAGES) - 1; k >= 0; k--) begin
      a            = !stage_valid[k] || (stage_ready_go[k] && a);
      allow[k]     = a;
      kill_hold[k] = f;
      f            = f | flush[k];
      kill_in[k]   = f;
    end

    src_valid[0] = in_valid;
    src_bus[0]   = in_bus;
    for (int k = 1; k < int'(NUM_STAGES); k++) begin
      src_valid[k] = stage_valid[k-1] && stage_ready_go[k-1];
      src_bus[k]   = stage_next_bus[(k-1)*BUS_W +: BUS_W];
    end

    for (int k = 0; k < int'(NUM_STAGES); k++) begin
      load[k] = allow[k] && src_valid[k] && !kill_in[k];
    end
  end

  // Stage registers: a stage younger than a flushing stage clears even under back-pressure.
  always_ff @(posedge clk or negedge resetn) begin
    if (!resetn) begin
      stage_valid <= '0;
      stage_bus   <= '0;
    end else begin
      for (int k = 0; k < int'(NUM_STAGES); k++) begin
        if (kill_hold[k]) begin
          stage_valid[k] <= 1'b0;
        end else if (allow[k]) begin
          stage_valid[k] <= src_valid[k] && !kill_in[k];
        end
        if (load[k]) begin
          stage_bus[k*BUS_W +: BUS_W] <= src_bus[k];
        end
      end
    end
  end

  assign in_allow_in = allow[0] && !(|flush);
  assign out_valid   = stage_valid[NUM_STAGES-1] && stage_ready_go[NUM_STAGES-1];
  assign out_bus     = stage_next_bus[(NUM_STAGES-1)*BUS_W +: BUS_W];

`ifdef PIPE_STALL_CNT_EN
  logic [NUM_STAGES-1:0] stall;

  // A stage counts as stalled when it holds a live item that cannot move on this cycle.
  always_comb begin
    stall = '0;
    for (int k = 0; k < int'(NUM_STAGES); k++) begin
      stall[k] = stage_valid[k] && !(stage_ready_go[k] && allow[k+1]) && !kill_hold[k];
    end
  end

  always_ff @(posedge clk or negedge resetn) begin
    if (!resetn) begin
      perf_stall_cnt <= '0;
    end else begin
      for (int k = 0; k < int'(NUM_STAGES); k++) begin
        if (stall[k] && (perf_stall_cnt[k*CNT_W +: CNT_W] != {CNT_W{1'b1}})) begin
          perf_stall_cnt[k*CNT_W +: CNT_W] <= perf_stall_cnt[k*CNT_W +: CNT_W] + CNT_W'(1);
        end
      end
    end
  end
`endif

endmodule

// File: tb/tb_pipe_stage_chain.sv
// Directed self-checking bench for pipe_stage_chain (NUM_STAGES=5, BUS_W=64).
module tb_pipe_stage_chain;

  localparam int unsigned N = 5;
  localparam int unsigned W = 64;

  logic           clk;
  logic           resetn;
  logic           in_valid;
  logic           in_allow_in;
  logic [W-1:0]   in_bus;
  logic [N-1:0]   stage_ready_go;
  logic [N*W-1:0] stage_next_bus;
  logic [N-1:0]   flush;
  logic [N-1:0]   stage_valid;
  logic [N*W-1:0] stage_bus;
  logic           out_valid;
  logic           out_allow_in;
  logic [W-1:0]   out_bus;
`ifdef PIPE_STALL_CNT_EN
  logic [N*32-1:0] perf_stall_cnt;
`endif

  int vectors;
  int miscompares;

  assign stage_next_bus = stage_bus;

  pipe_stage_chain #(.NUM_STAGES(N), .BUS_W(W)) dut (
    .clk            (clk),
    .resetn         (resetn),
    .in_valid       (in_valid),
    .in_allow_in    (in_allow_in),
    .in_bus         (in_bus),
    .stage_ready_go (stage_ready_go),
    .stage_next_bus (stage_next_bus),
    .flush          (flush),
    .stage_valid    (stage_valid),
    .stage_bus      (stage_bus),
    .out_valid      (out_valid),
    .out_allow_in   (out_allow_in),
    .out_bus        (out_bus)
`ifdef PIPE_STALL_CNT_EN
    ,
    .perf_stall_cnt (perf_stall_cnt)
`endif
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic check(input string tag, input logic [319:0] obs, input logic [319:0] exp);
    vectors++;
    assert (obs === exp)
    else begin
      miscompares++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  function automatic logic [319:0] pack5(input logic [63:0] a0, input logic [63:0] a1,
                                         input logic [63:0] a2, input logic [63:0] a3,
                                         input logic [63:0] a4);
    return {a4, a3, a2, a1, a0};
  endfunction

  initial begin
    vectors        = 0;
    miscompares    = 0;
    resetn         = 1'b0;
    in_valid       = 1'b0;
    in_bus         = '0;
    stage_ready_go = '1;
    flush          = '0;
    out_allow_in   = 1'b1;

    // Reset state
    tick();
    check("rst_valid", 320'(stage_valid), 320'(0));
    check("rst_bus", 320'(stage_bus), 320'(0));
    check("rst_out_valid", 320'(out_valid), 320'(0));
    check("rst_allow_in", 320'(in_allow_in), 320'(1));
`ifdef PIPE_STALL_CNT_EN
    check("rst_cnt", 320'(perf_stall_cnt), 320'(0));
`endif
    flush = 5'b00001;
    #1;
    check("rst_allow_in_flush", 320'(in_allow_in), 320'(0));
    flush = '0;

    // Streaming: item e-1 enters at edge e, leaves stage 4 after edge e+4
    resetn   = 1'b1;
    in_valid = 1'b1;
    in_bus   = 64'd0;
    for (int e = 1; e <= 15; e++) begin
      tick();
      check("stream_out_valid", 320'(out_valid), 320'(e >= 5 ? 1 : 0));
      if (e >= 5) check("stream_out_bus", 320'(out_bus), 320'(64'(e - 5)));
      if (e == 1) check("stream_first_valid", 320'(stage_valid), 320'(5'b00001));
      in_bus = 64'(e);
    end
    check("full_bus_10_14", 320'(stage_bus), pack5(64'd14, 64'd13, 64'd12, 64'd11, 64'd10));

    // Consumer back-pressure for 3 cycles
    out_allow_in = 1'b0;
    for (int h = 0; h < 3; h++) begin
      #1;
      check("bp_allow_in", 320'(in_allow_in), 320'(0));
      tick();
      check("bp_frozen", 320'(stage_bus), pack5(64'd14, 64'd13, 64'd12, 64'd11, 64'd10));
    end
    check("bp_out_bus", 320'(out_bus), 320'(64'd10));
    out_allow_in = 1'b1;
    for (int r = 1; r <= 3; r++) begin
      tick();
      check("bp_release_out", 320'(out_bus), 320'(64'(10 + r)));
      in_bus = 64'(15 + r);
    end
    check("pre_stall_bus", 320'(stage_bus), pack5(64'd17, 64'd16, 64'd15, 64'd14, 64'd13));

    // Stage 2 stalls for 2 cycles
    stage_ready_go = 5'b11011;
    #1;
    check("stall_allow_in", 320'(in_allow_in), 320'(0));
    tick();
    check("stall1_valid", 320'(stage_valid), 320'(5'b10111));
    check("stall1_out_bus", 320'(out_bus), 320'(64'd14));
    tick();
    check("stall2_valid", 320'(stage_valid), 320'(5'b00111));
    check("stall2_out_valid", 320'(out_valid), 320'(0));
`ifdef PIPE_STALL_CNT_EN
    check("stall_cnt2", 320'(perf_stall_cnt[2*32 +: 32]), 320'(32'd5));
`endif
    stage_ready_go = '1;
    tick();
    check("stall_resume_valid", 320'(stage_valid), 320'(5'b01111));
    in_bus = 64'd19;
    tick();
    check("stall_resume_out", 320'(out_bus), 320'(64'd15));
    check("stall_resume_bus", 320'(stage_bus), pack5(64'd19, 64'd18, 64'd17, 64'd16, 64'd15));

    // Fill with 20..24 then flush from stage 2
    for (int v = 20; v <= 24; v++) begin
      in_bus = 64'(v);
      tick();
      check("fill_out", 320'(out_bus), 320'(64'(v - 4)));
    end
    flush  = 5'b00100;
    in_bus = 64'd25;
    #1;
    check("flush2_allow_in", 320'(in_allow_in), 320'(0));
    tick();
    flush = '0;
    check("flush2_valid", 320'(stage_valid), 320'(5'b11000));
    check("flush2_s3_bus", 320'(stage_bus[3*64 +: 64]), 320'(64'd22));
    check("flush2_out", 320'(out_bus), 320'(64'd21));
    tick();
    check("flush2_out22", 320'(out_bus), 320'(64'd22));
    check("flush2_refill_valid", 320'(stage_valid), 320'(5'b10001));
    in_bus = 64'd26;
    tick();
    check("flush2_gap", 320'(out_valid), 320'(0));
    in_bus = 64'd27;
    tick();
    in_bus = 64'd28;
    tick();
    check("flush2_gap2", 320'(out_valid), 320'(0));
    in_bus = 64'd29;
    tick();
    check("flush2_next_valid", 320'(out_valid), 320'(1));
    check("flush2_next_out", 320'(out_bus), 320'(64'd25));
    check("flush2_full", 320'(stage_bus), pack5(64'd29, 64'd28, 64'd27, 64'd26, 64'd25));

    // Two flush sources: the older one (stage 3) dominates
    flush  = 5'b01010;
    in_bus = 64'd30;
    #1;
    check("flush31_allow_in", 320'(in_allow_in), 320'(0));
    tick();
    flush = '0;
    check("flush31_valid", 320'(stage_valid), 320'(5'b10000));
    check("flush31_out", 320'(out_bus), 320'(64'd26));
    check("flush31_out_valid", 320'(out_valid), 320'(1));

    // Asynchronous reset between edges
    #2;
    resetn = 1'b0;
    #1;
    check("async_valid", 320'(stage_valid), 320'(0));
    check("async_out_valid", 320'(out_valid), 320'(0));
    check("async_bus", 320'(stage_bus), 320'(0));
    check("async_allow_in", 320'(in_allow_in), 320'(1));
`ifdef PIPE_STALL_CNT_EN
    check("async_cnt", 320'(perf_stall_cnt), 320'(0));
`endif
    tick();
    resetn = 1'b1;
    in_bus = 64'd40;
    tick();
    check("post_rst_valid", 320'(stage_valid), 320'(5'b00001));
    check("post_rst_bus", 320'(stage_bus[63:0]), 320'(64'd40));

    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

endmodule
